// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline stage registers: stage state encoding,
// the NOP control value and bit positions used when callers pack their bundles.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        STATE_EMPTY = ST_EMPTY,
        STATE_BUSY  = ST_BUSY,
        STATE_FULL  = ST_FULL
    } state_e;

    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    localparam int CF_REG_WRITE = 0;
    localparam int CF_MEM_WRITE = 1;
    localparam int CF_MEM_READ  = 2;
    localparam int CF_JUMP      = 3;
    localparam int CF_BRANCH    = 4;
    localparam int CF_ALU_SRC   = 5;
    localparam int CF_WB_SEL    = 6;

    localparam int DF_RD_LSB  = 0;
    localparam int DF_RD_W    = 5;
    localparam int DF_IMM_LSB = DF_RD_LSB + DF_RD_W;
    localparam int DF_IMM_W   = 12;
    localparam int DF_PC_LSB  = DF_IMM_LSB + DF_IMM_W;
    localparam int DF_PC_W    = DATA_W_DEF - DF_PC_LSB;

    function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(
        input logic reg_write,
        input logic mem_write,
        input logic mem_read,
        input logic jump,
        input logic branch,
        input logic alu_src,
        input logic wb_sel
    );
        logic [CTRL_W_DEF-1:0] c;
        c = CTRL_NOP;
        c[CF_REG_WRITE] = reg_write;
        c[CF_MEM_WRITE] = mem_write;
        c[CF_MEM_READ]  = mem_read;
        c[CF_JUMP]      = jump;
        c[CF_BRANCH]    = branch;
        c[CF_ALU_SRC]   = alu_src;
        c[CF_WB_SEL]    = wb_sel;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One held pipeline entry (control + data). Clear turns the control into a NOP while
// leaving the data untouched, so a bubble keeps the last datapath value on the wires.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clear) begin
            ctrl_d = '0;
        end else if (load) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
        end
    end

    // The core's stage registers update on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign out_ctrl = ctrl_q;
    assign out_data = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an optional
// skid entry that makes in_ready a registered signal.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    import pipe_pkg::*;

    state_e state_q, state_d;

    logic accept;
    logic retire;
    logic main_load;
    logic main_clear;
    logic main_from_skid;
    logic skid_load;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_in_ctrl;
    logic [DATA_W-1:0] main_in_data;

    assign out_valid = (state_q != STATE_EMPTY);
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d    = STATE_EMPTY;
            main_clear = 1'b1;
        end else if (SKID == 0) begin
            if (accept) begin
                main_load = 1'b1;
                state_d   = STATE_BUSY;
            end else if (retire) begin
                main_clear = 1'b1;
                state_d    = STATE_EMPTY;
            end
        end else begin
            case (state_q)
                STATE_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = STATE_BUSY;
                    end
                end
                STATE_BUSY: begin
                    if (accept && retire) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = STATE_FULL;
                    end else if (retire) begin
                        main_clear = 1'b1;
                        state_d    = STATE_EMPTY;
                    end
                end
                STATE_FULL: begin
                    // Upstream is blocked here, so only the skid entry can move.
                    if (retire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = STATE_BUSY;
                    end
                end
                default: begin
                    state_d    = STATE_EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
        main_in_data = main_from_skid ? skid_data : in_data;
    end

    pipe_slot #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .out_ctrl(out_ctrl),
        .out_data(out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            assign in_ready_d = (state_d != STATE_FULL);

            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;

            pipe_slot #(
                .DATA_W(DATA_W),
                .CTRL_W(CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (flush),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .out_ctrl(skid_ctrl),
                .out_data(skid_data)
            );
        end else begin : g_noskid
            logic unused_skid_load;
            assign unused_skid_load = skid_load;
            assign skid_ctrl        = '0;
            assign skid_data        = '0;
            assign in_ready         = out_ready | ~out_valid;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=0 and one SKID=1 instance, each
// checked against a FIFO model of at most 1 / 2 entries.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  in_ctrl   [2];
    logic [31:0] in_data   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [7:0]  out_ctrl  [2];
    logic [31:0] out_data  [2];
    logic [1:0]  occupancy [2];

    ent_t        sb0[$];
    ent_t        sb1[$];
    logic [31:0] last_data  [2];
    int          retire_cnt [2];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          verbose  = 1'b1;

    always #10 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
        .occupancy(occupancy[0])
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
        .occupancy(occupancy[1])
    );

    function automatic int q_size(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic ent_t q_head(input int k);
        return (k == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic q_pop(input int k);
        if (k == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
    endtask

    task automatic q_push(input int k, input ent_t e);
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic q_clear(input int k);
        if (k == 0) sb0.delete();
        else        sb1.delete();
    endtask

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    // Compare the DUT against the model, then advance the model by this cycle's handshake.
    task automatic mon_step(input int k);
        int   n;
        ent_t h;
        logic exp_rdy;
        if (rst) return;
        n = q_size(k);
        exp_rdy = (k == 1) ? (n < 2) : (out_ready[k] || n == 0);
        chk("out_valid", k, 64'(out_valid[k]), 64'(n > 0));
        chk("occupancy", k, 64'(occupancy[k]), 64'(n));
        chk("in_ready",  k, 64'(in_ready[k]),  64'(exp_rdy));
        if (n > 0) begin
            h = q_head(k);
            last_data[k] = h.d;
            chk("out_ctrl", k, 64'(out_ctrl[k]), 64'(h.c));
            chk("out_data", k, 64'(out_data[k]), 64'(h.d));
        end else begin
            chk("bubble_ctrl", k, 64'(out_ctrl[k]), 64'(0));
            chk("bubble_data", k, 64'(out_data[k]), 64'(last_data[k]));
        end
        if (flush[k]) begin
            q_clear(k);
        end else if (n > 0 && out_ready[k]) begin
            if (verbose) $display("dut%0d retire ctrl=0x%02h data=0x%08h", k, h.c, h.d);
            retire_cnt[k]++;
            q_pop(k);
        end
    endtask

    always @(posedge clk) begin
        #4;
        for (int k = 0; k < 2; k++) mon_step(k);
    end

    task automatic cycle(input int k, input logic v, input logic [7:0] c, input logic [31:0] d,
                         input logic ordy, input logic fl, output logic acc);
        @(posedge clk);
        #2;
        in_valid[k]  = v;
        in_ctrl[k]   = c;
        in_data[k]   = d;
        out_ready[k] = ordy;
        flush[k]     = fl;
        #4;
        acc = v && in_ready[k] && !fl && !rst;
        if (acc) begin
            q_push(k, {c, d});
            if (verbose) $display("dut%0d accept ctrl=0x%02h data=0x%08h", k, c, d);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            q_clear(k);
            last_data[k] = '0;
        end
    endtask

    task automatic rand_run(input int k, input int ncyc);
        logic        v, acc, fl, ordy;
        logic [7:0]  c;
        logic [31:0] d;
        v   = 1'b0;
        acc = 1'b1;
        fl  = 1'b0;
        c   = '0;
        d   = '0;
        for (int i = 0; i < ncyc; i++) begin
            // A refused entry is held stable until it is taken, unless a flush dropped it.
            if (!(v && !acc && !fl)) begin
                v = ($urandom_range(0, 3) != 0);
                c = 8'($urandom);
                d = $urandom;
            end
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            cycle(k, v, c, d, ordy, fl, acc);
        end
        cycle(k, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        cycle(k, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   rc;
        for (int k = 0; k < 2; k++) begin
            flush[k]      = 1'b0;
            in_valid[k]   = 1'b0;
            in_ctrl[k]    = '0;
            in_data[k]    = '0;
            out_ready[k]  = 1'b0;
            retire_cnt[k] = 0;
        end
        model_reset();

        repeat (2) @(posedge clk);
        #7;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 64'(out_valid[k]), 64'(0));
            chk("rst_ctrl",  k, 64'(out_ctrl[k]),  64'(0));
            chk("rst_data",  k, 64'(out_data[k]),  64'(0));
            chk("rst_occ",   k, 64'(occupancy[k]), 64'(0));
        end
        chk("rst_ready", 1, 64'(in_ready[1]), 64'(1));
        rst = 1'b0;

        // Streaming at full rate through the skid stage.
        for (int i = 1; i <= 8; i++) cycle(1, 1'b1, 8'(i), 32'(i), 1'b1, 1'b0, acc);
        cycle(1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        cycle(1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        chk("stream_count", 1, 64'(retire_cnt[1]), 64'(8));

        // Stall fills main then skid; the held third offer must be ignored.
        cycle(1, 1'b1, 8'hA5, 32'h100, 1'b0, 1'b0, acc);
        cycle(1, 1'b1, 8'hA5, 32'h200, 1'b0, 1'b0, acc);
        cycle(1, 1'b1, 8'hA5, 32'h200, 1'b0, 1'b0, acc);
        chk("stall_occ",   1, 64'(occupancy[1]), 64'(2));
        chk("stall_ready", 1, 64'(in_ready[1]),  64'(0));
        rc = retire_cnt[1];
        for (int i = 0; i < 3; i++) cycle(1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        chk("stall_release", 1, 64'(retire_cnt[1] - rc), 64'(2));

        // Flush with two entries held and a new offer on the input.
        cycle(1, 1'b1, 8'h5A, 32'h111, 1'b0, 1'b0, acc);
        cycle(1, 1'b1, 8'h22, 32'h222, 1'b0, 1'b0, acc);
        cycle(1, 1'b1, 8'hC3, 32'h300, 1'b0, 1'b1, acc);
        cycle(1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        chk("flush_valid", 1, 64'(out_valid[1]), 64'(0));
        chk("flush_ctrl",  1, 64'(out_ctrl[1]),  64'(0));
        chk("flush_occ",   1, 64'(occupancy[1]), 64'(0));
        chk("flush_ready", 1, 64'(in_ready[1]),  64'(1));

        // Flush from one entry while the input is ready: 0x301 must be dropped too.
        cycle(1, 1'b1, 8'h33, 32'h500, 1'b0, 1'b0, acc);
        cycle(1, 1'b1, 8'h44, 32'h301, 1'b0, 1'b1, acc);
        rc = retire_cnt[1];
        for (int i = 0; i < 3; i++) cycle(1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        chk("flush_busy_drop", 1, 64'(retire_cnt[1] - rc), 64'(0));

        // Asynchronous reset with two entries held.
        cycle(1, 1'b1, 8'h77, 32'h401, 1'b0, 1'b0, acc);
        cycle(1, 1'b1, 8'h78, 32'h402, 1'b0, 1'b0, acc);
        @(posedge clk);
        #7;
        rst = 1'b1;
        in_valid[1] = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 1, 64'(out_valid[1]), 64'(0));
        chk("arst_ctrl",  1, 64'(out_ctrl[1]),  64'(0));
        chk("arst_occ",   1, 64'(occupancy[1]), 64'(0));
        chk("arst_ready", 1, 64'(in_ready[1]),  64'(1));
        @(posedge clk);
        #7;
        rst = 1'b0;

        // Single-register stage: in_ready follows out_ready combinationally.
        cycle(0, 1'b1, 8'h11, 32'hAA, 1'b1, 1'b0, acc);
        cycle(0, 1'b1, 8'h22, 32'hBB, 1'b0, 1'b0, acc);
        chk("s0_stall_ready", 0, 64'(in_ready[0]), 64'(0));
        cycle(0, 1'b1, 8'h22, 32'hBB, 1'b1, 1'b0, acc);
        chk("s0_accept", 0, 64'(acc), 64'(1));
        chk("s0_ready",  0, 64'(in_ready[0]), 64'(1));
        cycle(0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);
        cycle(0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, acc);

        verbose = 1'b0;
        fork
            rand_run(0, 10000);
            rand_run(1, 10000);
        join
        chk("final_empty", 0, 64'(q_size(0)), 64'(0));
        chk("final_empty", 1, 64'(q_size(1)), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
